// File: rtl/keypad_emulator.sv
// keypad_emulator: responder end of a 4x4 column-scan / row-sense keypad.
// On request it "presses" one key. The contact closes with deterministic
// bounce, stays closed for a programmable hold time, and reopens with bounce.
// A released dwell follows before the keystroke reports completion.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   press_req    request one keystroke (accepted only while busy=0)
//   key_code     hex key to press, latched on accept
//   hold_cycles  stable-closed duration, latched on accept (0 behaves as 1)
//   col_d        column drive from the scanner, active-low
//   row_q        row sense back to the scanner, active-low (combinational)
//   contact_q    registered contact state, 1 = closed
//   busy         keystroke in progress
//   done         one-cycle pulse in the first idle cycle after a keystroke
module keypad_emulator #(
    parameter int BOUNCE_TOGGLES = 3,
    parameter int BOUNCE_PERIOD  = 4800,
    parameter int GAP_CYCLES     = 48000,
    parameter int HOLD_W         = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              press_req,
    input  logic [3:0]        key_code,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [3:0]        col_d,
    output logic [3:0]        row_q,
    output logic              contact_q,
    output logic              busy,
    output logic              done
);

    // The segment counter must hold the largest reload value of any phase.
    localparam int PER_W  = $clog2(BOUNCE_PERIOD + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int CNT_W0 = (PER_W > GAP_W) ? PER_W : GAP_W;
    localparam int CNT_W  = (CNT_W0 > HOLD_W) ? CNT_W0 : HOLD_W;
    localparam int SEG_N  = 2 * BOUNCE_TOGGLES;
    localparam int SEG_W  = (SEG_N > 1) ? $clog2(SEG_N) : 1;

    // Counters hold "cycles remaining minus one", so a segment ends when the counter reads zero.
    localparam logic [CNT_W-1:0]  PERIOD_LD = CNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [CNT_W-1:0]  GAP_LD    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [SEG_W-1:0]  SEG_LAST  = SEG_W'(SEG_N - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [3:0]        key_q, key_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              contact_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [HOLD_W-1:0] hold_eff_s;
    logic [3:0]        key_rc_s;

    // Keypad layout: returns {row[1:0], col[1:0]} for a hex key code.
    function automatic logic [3:0] key_to_rc(input logic [3:0] key);
        logic [3:0] rc;
        case (key)
            4'h1:    rc = {2'd0, 2'd0};
            4'h2:    rc = {2'd0, 2'd1};
            4'h3:    rc = {2'd0, 2'd2};
            4'hA:    rc = {2'd0, 2'd3};
            4'h4:    rc = {2'd1, 2'd0};
            4'h5:    rc = {2'd1, 2'd1};
            4'h6:    rc = {2'd1, 2'd2};
            4'hB:    rc = {2'd1, 2'd3};
            4'h7:    rc = {2'd2, 2'd0};
            4'h8:    rc = {2'd2, 2'd1};
            4'h9:    rc = {2'd2, 2'd2};
            4'hC:    rc = {2'd2, 2'd3};
            4'hE:    rc = {2'd3, 2'd0};
            4'h0:    rc = {2'd3, 2'd1};
            4'hF:    rc = {2'd3, 2'd2};
            4'hD:    rc = {2'd3, 2'd3};
            default: rc = {2'd0, 2'd0};
        endcase
        return rc;
    endfunction

    assign hold_eff_s = (hold_cycles == {HOLD_W{1'b0}}) ? HOLD_ONE : hold_cycles;
    assign key_rc_s   = key_to_rc(key_q);
    assign busy       = busy_q;
    assign done       = done_q;

    // Row sense: only the latched key's column bit can pull its row low.
    always_comb begin
        row_q = 4'b1111;
        if (contact_q && (col_d[key_rc_s[1:0]] == 1'b0)) begin
            row_q[key_rc_s[3:2]] = 1'b0;
        end else begin
            row_q = 4'b1111;
        end
    end

    // Keystroke sequencer: next state, segment counter reloads and contact level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        key_d   = key_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_req) begin
                    key_d  = key_code;
                    hold_d = hold_eff_s;
                    seg_d  = {SEG_W{1'b0}};
                    if (BOUNCE_TOGGLES > 0) begin
                        state_d = ST_PRESS;
                        cnt_d   = PERIOD_LD;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(hold_eff_s - HOLD_ONE);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (seg_q == SEG_LAST) begin
                    state_d = ST_HOLD;
                    seg_d   = {SEG_W{1'b0}};
                    cnt_d   = CNT_W'(hold_q - HOLD_ONE);
                end else begin
                    seg_d = seg_q + SEG_W'(1);
                    cnt_d = PERIOD_LD;
                end
            end
            ST_HOLD: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (BOUNCE_TOGGLES > 0) begin
                    state_d = ST_RELEASE;
                    seg_d   = {SEG_W{1'b0}};
                    cnt_d   = PERIOD_LD;
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end
            end
            ST_RELEASE: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (seg_q == SEG_LAST) begin
                    state_d = ST_GAP;
                    seg_d   = {SEG_W{1'b0}};
                    cnt_d   = GAP_LD;
                end else begin
                    seg_d = seg_q + SEG_W'(1);
                    cnt_d = PERIOD_LD;
                end
            end
            ST_GAP: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                seg_d   = {SEG_W{1'b0}};
            end
        endcase

        // Press bounce starts closed (even segments closed); release bounce starts open.
        case (state_d)
            ST_PRESS:   contact_d = ~seg_d[0];
            ST_HOLD:    contact_d = 1'b1;
            ST_RELEASE: contact_d = seg_d[0];
            default:    contact_d = 1'b0;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            seg_q     <= {SEG_W{1'b0}};
            key_q     <= 4'h0;
            hold_q    <= {HOLD_W{1'b0}};
            contact_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seg_q     <= seg_d;
            key_q     <= key_d;
            hold_q    <= hold_d;
            contact_q <= contact_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator. Two instances share all stimulus:
//   inst0: clean edges (no bounce), gap 5
//   inst1: 2 bounce toggles of 3 cycles, gap 5
// A keystroke-level model predicts busy/contact/done/row every cycle.
// Directed keystrokes add literal expectations on top of the model.
module tb_keypad_emulator;
    localparam int HW  = 4;
    localparam int T0  = 0;
    localparam int P0  = 2;
    localparam int G0  = 5;
    localparam int T1  = 2;
    localparam int P1  = 3;
    localparam int G1  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          press_req = 1'b0;
    logic [3:0]    key_code = 4'h0;
    logic [HW-1:0] hold_cycles = '0;
    logic [3:0]    col_d = 4'hF;
    logic [3:0]    row_v [2];
    logic [1:0]    contact_v, busy_v, done_v;

    int checks = 0;
    int failures = 0;

    // model state
    bit m_act [2];
    bit m_done [2];
    int m_pos [2];
    int m_hold [2];
    int m_key [2];

    // monitor state
    int run_len [2];
    int last_len [2];
    int done_cnt [2];
    int idle_cnt [2];
    int hits, last_hits;
    bit bseq [64];
    bit last_bseq [64];

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_TOGGLES(T0), .BOUNCE_PERIOD(P0), .GAP_CYCLES(G0), .HOLD_W(HW)) u_dut0 (
        .clk(clk), .rst(rst), .press_req(press_req), .key_code(key_code),
        .hold_cycles(hold_cycles), .col_d(col_d), .row_q(row_v[0]),
        .contact_q(contact_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    keypad_emulator #(.BOUNCE_TOGGLES(T1), .BOUNCE_PERIOD(P1), .GAP_CYCLES(G1), .HOLD_W(HW)) u_dut1 (
        .clk(clk), .rst(rst), .press_req(press_req), .key_code(key_code),
        .hold_cycles(hold_cycles), .col_d(col_d), .row_q(row_v[1]),
        .contact_q(contact_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    function automatic int p_t(input int i); return (i == 0) ? T0 : T1; endfunction
    function automatic int p_p(input int i); return (i == 0) ? P0 : P1; endfunction
    function automatic int p_g(input int i); return (i == 0) ? G0 : G1; endfunction

    function automatic int total_len(input int i, input int h);
        return 4 * p_t(i) * p_p(i) + h + p_g(i);
    endfunction

    // Contact level at position pos (0-based cycle) of a keystroke.
    function automatic bit exp_contact(input int i, input int h, input int pos);
        int bp;
        bp = 2 * p_t(i) * p_p(i);
        if (pos < bp) return ((pos / p_p(i)) % 2) == 0;
        if (pos < bp + h) return 1'b1;
        if (pos < 2 * bp + h) return (((pos - bp - h) / p_p(i)) % 2) == 1;
        return 1'b0;
    endfunction

    // Physical keypad layout, read row by row.
    function automatic logic [3:0] exp_row(input int key, input bit con, input logic [3:0] col);
        int lay [16];
        int r, c;
        logic [3:0] res;
        lay = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
        r = 0;
        c = 0;
        for (int k = 0; k < 16; k++) begin
            if (lay[k] == key) begin
                r = k / 4;
                c = k % 4;
            end
        end
        res = 4'hF;
        if (con && col[c] == 1'b0) res[r] = 1'b0;
        return res;
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", name, i, act, exp, $time);
        end
    endtask

    // Reference model: advances one keystroke position per clock.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_act[i] = 1'b0;
                    m_done[i] = 1'b0;
                    m_pos[i] = 0;
                    m_key[i] = 0;
                end else if (m_act[i]) begin
                    m_pos[i]++;
                    m_done[i] = 1'b0;
                    if (m_pos[i] == total_len(i, m_hold[i])) begin
                        m_act[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end else begin
                    m_done[i] = 1'b0;
                    if (press_req) begin
                        m_act[i] = 1'b1;
                        m_pos[i] = 0;
                        m_hold[i] = (hold_cycles == '0) ? 1 : int'(hold_cycles);
                        m_key[i] = int'(key_code);
                    end
                end
            end
        end
    end

    // Compare process and keystroke monitors, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 2; i++) run_len[i] = 0;
                hits = 0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    bit ec;
                    ec = m_act[i] ? exp_contact(i, m_hold[i], m_pos[i]) : 1'b0;
                    chk("busy", i, int'(busy_v[i]), int'(m_act[i]));
                    chk("contact", i, int'(contact_v[i]), int'(ec));
                    chk("done", i, int'(done_v[i]), int'(m_done[i]));
                    chk("row", i, int'(row_v[i]), int'(exp_row(m_key[i], ec, col_d)));
                    if (busy_v[i]) begin
                        if (i == 1 && run_len[i] < 64) bseq[run_len[i]] = contact_v[i];
                        if (i == 0 && row_v[0] == 4'b1101) hits++;
                        run_len[i]++;
                    end else begin
                        idle_cnt[i]++;
                    end
                    if (done_v[i]) begin
                        done_cnt[i]++;
                        last_len[i] = run_len[i];
                        run_len[i] = 0;
                        if (i == 0) begin
                            last_hits = hits;
                            hits = 0;
                        end else begin
                            last_bseq = bseq;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_v != 2'b00 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (busy_v != 2'b00) chk("idle_timeout", 0, int'(busy_v), 0);
    endtask

    // One directed keystroke; key/hold are scrambled right after accept.
    task automatic keystroke(input logic [3:0] k, input int h, input logic [3:0] col, input bit rot);
        wait_idle();
        @(posedge clk);
        #2;
        press_req = 1'b1;
        key_code = k;
        hold_cycles = HW'(h);
        col_d = col;
        @(posedge clk);
        #2;
        press_req = 1'b0;
        key_code = ~k;
        hold_cycles = HW'($urandom);
        for (int n = 0; n < 400 && busy_v != 2'b00; n++) begin
            if (rot) col_d = {col_d[2:0], col_d[3]};
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        int d0, d1, i0;
        int runs [10];
        int idx;
        bit lvl;
        runs = '{3, 3, 3, 3, 10, 3, 3, 3, 3, 5};
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0;
            idle_cnt[i] = 0;
            run_len[i] = 0;
            last_len[i] = 0;
        end
        hits = 0;
        last_hits = 0;

        // reset state
        #23;
        for (int i = 0; i < 2; i++) begin
            chk("rst_row", i, int'(row_v[i]), 4'hF);
            chk("rst_busy", i, int'(busy_v[i]), 0);
            chk("rst_done", i, int'(done_v[i]), 0);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;

        // clean-edge mapping: key 5 hold 10, column 1 driven
        d0 = done_cnt[0];
        keystroke(4'h5, 10, 4'b1101, 1'b0);
        chk("len_clean", 0, last_len[0], 15);
        chk("hits_clean", 0, last_hits, 10);
        chk("done_once", 0, done_cnt[0] - d0, 1);

        // bounce pattern: key D hold 10, column 3 driven
        keystroke(4'hD, 10, 4'b0111, 1'b0);
        chk("len_bounce", 1, last_len[1], 39);
        idx = 0;
        lvl = 1'b1;
        for (int r = 0; r < 10; r++) begin
            for (int n = 0; n < runs[r]; n++) begin
                chk("bounce_seq", 1, int'(last_bseq[idx]), int'(lvl));
                idx++;
            end
            lvl = ~lvl;
        end

        // column filtering with a rotating scan
        keystroke(4'h5, 10, 4'b1110, 1'b1);
        chk("len_scan", 0, last_len[0], 15);

        // hold edge cases
        keystroke(4'h2, 0, 4'b1101, 1'b0);
        chk("len_hold0", 0, last_len[0], 6);
        chk("len_hold0", 1, last_len[1], 30);
        keystroke(4'hB, 15, 4'b0111, 1'b0);
        chk("len_hold15", 0, last_len[0], 20);
        chk("len_hold15", 1, last_len[1], 44);

        // reset mid-HOLD of inst1 with key 4 on column 0
        wait_idle();
        @(posedge clk);
        #2;
        press_req = 1'b1;
        key_code = 4'h4;
        hold_cycles = HW'(15);
        col_d = 4'b1110;
        @(posedge clk);
        #2;
        press_req = 1'b0;
        repeat (12 + $urandom_range(1, 10)) @(posedge clk);
        #1;
        chk("pre_rst_contact", 1, int'(contact_v[1]), 1);
        chk("pre_rst_row", 1, int'(row_v[1]), 4'b1101);
        d0 = done_cnt[0] + done_cnt[1];
        rst = 1'b1;
        #1;
        chk("async_row", 1, int'(row_v[1]), 4'hF);
        chk("async_busy", 1, int'(busy_v[1]), 0);
        chk("async_contact", 1, int'(contact_v[1]), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        chk("no_done_after_rst", 0, done_cnt[0] + done_cnt[1] - d0, 0);

        // press_req held high: back-to-back keystrokes, key changing every cycle
        press_req = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        #1;
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        i0 = idle_cnt[0];
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #2;
            key_code = 4'($urandom);
            hold_cycles = HW'($urandom);
            col_d = 4'($urandom);
        end
        @(negedge clk);
        #1;
        chk("b2b_idle_eq_done", 0, idle_cnt[0] - i0, done_cnt[0] - d0);
        chk("b2b_many", 0, int'((done_cnt[0] - d0) > 15), 1);
        chk("b2b_many", 1, int'((done_cnt[1] - d1) > 5), 1);

        // randomized traffic with occasional asynchronous reset
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #2;
            press_req = ($urandom_range(0, 3) == 0);
            key_code = 4'($urandom);
            hold_cycles = ($urandom_range(0, 3) == 0) ? HW'(0) : HW'($urandom);
            col_d = ($urandom_range(0, 1) == 0) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #1;
                rst = 1'b1;
                @(posedge clk);
                #3;
                rst = 1'b0;
            end
        end
        press_req = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Synthesizable 4x4 matrix-keypad model: the responder end of the column-scan/row-sense interface.
- Watches the column lines driven by a scanner and pulls the matching row line for one commanded key.
- Adds deterministic contact bounce on press and on release.
- Used for on-chip self-test and for benches of the scanner/debouncer path, replacing the physical keypad.

Parameters:
BOUNCE_TOGGLES, 3, bounce half-pairs per edge; 0 = clean edges with no bounce states.
BOUNCE_PERIOD, 4800, clk cycles per bounce segment; legal range ≥1.
GAP_CYCLES, 48000, released dwell after the release bounce, before done; legal range ≥1.
HOLD_W, 24, width of hold_cycles.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
press_req  input  1  request one keystroke; accepted only when busy=0
key_code  input  4  hex key to press; latched on accept
hold_cycles  input  HOLD_W  stable-closed duration; latched on accept, value 0 treated as 1
col_d  input  4  column drive from scanner, active-low; nominally one-hot-low
row_q  output  4  row sense to scanner, active-low; 1111 = no contact
contact_q  output  1  registered internal contact state, 1 = closed (for verification)
busy  output  1  keystroke in progress
done  output  1  one-cycle pulse at keystroke completion

Behaviour:
- Reset (async, rst=1): state IDLE, contact_q=0, busy=0, done=0, row_q=1111; counters and latches cleared. Reset mid-keystroke aborts immediately; there is no done pulse.
- Key map (row, col): 1(0,0) 2(0,1) 3(0,2) A(0,3); 4(1,0) 5(1,1) 6(1,2) B(1,3); 7(2,0) 8(2,1) 9(2,2) C(2,3); E(3,0) 0(3,1) F(3,2) D(3,3).
- row_q is combinational from col_d and registered state:
  - row_q[r]=0 iff contact_q=1, r = latched key row, and col_d[c]=0 for latched key column c.
  - All other row bits are 1.
  - Non-one-hot col_d: only the key's column bit matters. col_d=1111 gives row_q=1111.
- Accept: at a rising clk edge where press_req=1 and busy=0, latch key_code and max(hold_cycles,1), then enter PRESS_BOUNCE (or HOLD if BOUNCE_TOGGLES=0). busy=1 from the next cycle.
- press_req while busy=1 is ignored; it is not queued.
- PRESS_BOUNCE:
  - 2*BOUNCE_TOGGLES segments of BOUNCE_PERIOD cycles each.
  - contact_q alternates closed, open, closed, ..., last segment open.
- HOLD: contact_q=1 for exactly the latched hold count.
- RELEASE_BOUNCE:
  - 2*BOUNCE_TOGGLES segments of BOUNCE_PERIOD cycles each.
  - contact_q alternates open, closed, ..., last segment closed.
- GAP: contact_q=0 for GAP_CYCLES cycles, then IDLE.
- busy stays high for exactly 4*BOUNCE_TOGGLES*BOUNCE_PERIOD + hold + GAP_CYCLES cycles.
- done=1 for the single cycle in which busy first reads 0.
  - A press_req in that same cycle is accepted; done and the new acceptance may coincide.
- Segment counter: a single down-counter reloaded at each segment boundary.
  - Wide enough for max(BOUNCE_PERIOD, GAP_CYCLES, 2^HOLD_W-1).
  - It must not wrap; there is no off-by-one at segment edges.
- key_code and hold_cycles changes while busy have no effect.

Test Plan:
1. Reset behaviour: rst asserted at random time mid-HOLD with col_d=1110. Required: row_q=1111, busy=0, contact_q=0 asynchronously; no done after deassert.
2. Key mapping, clean edges: params T=0, GAP=5. key 0x5, hold 10, col_d=1101. Required:
   - busy high for 15 cycles.
   - row_q=1101 for the first 10 busy cycles, then 1111.
   - done pulses once.
3. Column filtering: same stimulus with col_d cycling 1110, 1101, 1011, 0111 each cycle. Required: row_q=1101 only in the cycles where col_d=1101 during HOLD; all others 1111.
4. Bounce pattern: T=2, P=3, GAP=5, key 0xD, hold 10, col_d=0111. Required:
   - busy high for 39 cycles.
   - contact_q sequence: 3 closed, 3 open, 3 closed, 3 open, 10 closed, 3 open, 3 closed, 3 open, 3 closed, 5 open.
   - row_q[3]=0 exactly when contact_q=1.
5. Request handling: press_req held high continuously. Required:
   - Back-to-back keystrokes; each new accept coincides with done.
   - A key_code change mid-keystroke takes effect only at the next accept.
6. Hold edge case: hold_cycles=0 → HOLD lasts exactly 1 cycle. hold_cycles=2^HOLD_W-1 with small HOLD_W=4 → 15 cycles, no wrap.
